// File: rtl/muldiv_iter_if.sv
// Pipeline <-> iterative mul/div unit: request, abort, MTHI/MTLO writes and HI/LO/status readback.
interface muldiv_iter_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              flush;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] hi_wdata;
    logic [DATA_W-1:0] lo_wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;

    modport master (
        output start, op, src_a, src_b, flush, hi_we, lo_we, hi_wdata, lo_wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hi_we, lo_we, hi_wdata, lo_wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, DATA_W cycles per operation.
// Define MULDIV_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate ops (op 100-111).
module muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_iter_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                op_ok;
    logic                accept;
    logic                launch_signed;
    logic                launch_div;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;

    logic                is_signed;
    logic                is_div;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] prod_step;

    logic                res_neg;
    logic [2*DATA_W-1:0] product_s;
    logic [2*DATA_W-1:0] mul_result;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

`ifdef MULDIV_MADD_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~bus.op[2];
`endif

    assign accept        = bus.start & ~bus.flush & op_ok;
    assign launch_signed = ~bus.op[0];
    assign launch_div    = (bus.op[2:1] == 2'b01);

    always_comb begin
        mag_a = bus.src_a;
        mag_b = bus.src_b;
        if (launch_signed && bus.src_a[DATA_W-1]) mag_a = -bus.src_a;
        if (launch_signed && bus.src_b[DATA_W-1]) mag_b = -bus.src_b;
    end

    assign is_signed = ~op_q[0];
    assign is_div    = (op_q[2:1] == 2'b01);

    // One iteration: multiply shifts right with a conditional add into the upper half,
    // divide shifts the remainder/quotient pair left and keeps the trial subtract if it fits.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (!is_div)
            prod_step = {mul_sum, prod_q[DATA_W-1:1]};
        else if (!div_diff[DATA_W])
            prod_step = {div_diff[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b1};
        else
            prod_step = {div_shift[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b0};
    end

    always_comb begin
        res_neg    = is_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        product_s  = res_neg ? -prod_q : prod_q;
        mul_result = product_s;
`ifdef MULDIV_MADD_EN
        if (op_q[2])
            mul_result = op_q[1] ? ({hi_q, lo_q} - product_s) : ({hi_q, lo_q} + product_s);
`endif
        quot = res_neg ? -prod_q[DATA_W-1:0] : prod_q[DATA_W-1:0];
        rem  = (is_signed && a_q[DATA_W-1]) ? -prod_q[2*DATA_W-1:DATA_W]
                                             : prod_q[2*DATA_W-1:DATA_W];
        // Divide-by-zero and signed overflow results are architectural, not algorithmic.
        if (b_q == '0) begin
            quot = '1;
            rem  = a_q;
        end else if (is_signed && a_q == MOST_NEG && b_q == '1) begin
            quot = MOST_NEG;
            rem  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.hi_wdata;
                    if (bus.lo_we) lo_q <= bus.lo_wdata;
                    if (accept) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        op_q    <= bus.op;
                        a_q     <= bus.src_a;
                        b_q     <= bus.src_b;
                        mcand_q <= launch_div ? mag_b : mag_a;
                        prod_q  <= {{DATA_W{1'b0}}, launch_div ? mag_a : mag_b};
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        prod_q <= prod_step;
                        if (cnt == CNT_LAST) begin
                            state <= ST_FIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    if (!bus.flush) begin
                        if (is_div) begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end else begin
                            {hi_q, lo_q} <= mul_result;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state == ST_RUN) || (state == ST_FIN);
    assign bus.done = (state == ST_FIN);

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed-vector bench for muldiv_iter (DATA_W = 32); covers MULDIV_MADD_EN in either build.
module tb_muldiv_iter;
    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_iter_if #(.DATA_W(W)) bus ();

    muldiv_iter #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic direct_write(input logic [W-1:0] hv, input logic [W-1:0] lv);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        bus.hi_wdata = hv; bus.lo_wdata = lv;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    // Launch one op, wait (bounded) for done, and return in the first IDLE cycle.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_op_timeout: done=%b after %0d cycles, required 1", bus.done, n);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.hi !== '0) begin errors++; $display("[TB] FAIL reset_hi: got %h required 0", bus.hi); end
        checks++; if (bus.lo !== '0) begin errors++; $display("[TB] FAIL reset_lo: got %h required 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b required 0", bus.done); end
    endtask

    task automatic test_mult_timing();
        bus.op = OP_MULT; bus.src_a = 32'hFFFF_FFFE; bus.src_b = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL timing_busy_k1: got %b required 1", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL timing_done_k1: got %b required 0", bus.done); end
        for (int i = 0; i < 31; i++) tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL timing_done_k32: got %b required 0", bus.done); end
        tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL timing_done_k33: got %b required 1", bus.done); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL timing_busy_k33: got %b required 1", bus.busy); end
        tick();
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h required ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h required fffffffa", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL timing_busy_k34: got %b required 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL timing_done_k34: got %b required 0", bus.done); end
    endtask

    task automatic test_vectors();
        vec_t v[10];
        v[0] = '{OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14};
        v[1] = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
        v[2] = '{OP_DIV,   32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF};
        v[3] = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        v[4] = '{OP_DIVU,  32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8,  32'hFFFF_FFFF};
        v[5] = '{OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD};
        v[6] = '{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001};
        v[7] = '{OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'h0000_0000};
        v[8] = '{OP_DIVU,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        v[9] = '{OP_MULT,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].op, v[i].a, v[i].b);
            checks++;
            if (bus.hi !== v[i].hi) begin errors++; $display("[TB] FAIL vec%0d_hi: got %h required %h", i, bus.hi, v[i].hi); end
            checks++;
            if (bus.lo !== v[i].lo) begin errors++; $display("[TB] FAIL vec%0d_lo: got %h required %h", i, bus.lo, v[i].lo); end
        end
    endtask

    task automatic test_flush();
        int pulses;
        direct_write(32'hAAAA_0000, 32'h0000_5555);
        bus.op = OP_MULTU; bus.src_a = 32'd7; bus.src_b = 32'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b required 0", bus.busy); end
        checks++; if (bus.hi !== 32'hAAAA_0000) begin errors++; $display("[TB] FAIL flush_hi: got %h required aaaa0000", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_5555) begin errors++; $display("[TB] FAIL flush_lo: got %h required 00005555", bus.lo); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL flush_no_done: got %0d pulses required 0", pulses); end
        bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_overrides_start: busy got %b required 0", bus.busy); end
    endtask

    task automatic test_start_while_busy();
        int n;
        bus.op = OP_MULTU; bus.src_a = 32'd7; bus.src_b = 32'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 25) begin errors++; $display("[TB] FAIL midrun_done_cycle: got %0d cycles required 25", n); end
        tick();
        checks++; if (bus.lo !== 32'd63) begin errors++; $display("[TB] FAIL midrun_lo: got %h required 0000003f", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL midrun_hi: got %h required 0", bus.hi); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_relaunch: busy got %b required 0", bus.busy); end
    endtask

    task automatic test_direct_write();
        direct_write(32'h0000_1111, 32'h0000_2222);
        bus.op = OP_MULTU; bus.src_a = 32'd2; bus.src_b = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b1; bus.hi_wdata = 32'h0000_1234;
        tick(); tick();
        bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'h0000_1111) begin errors++; $display("[TB] FAIL busy_write_hi: got %h required 00001111", bus.hi); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.hi !== 32'h0000_1111) begin errors++; $display("[TB] FAIL busy_write_after_flush: got %h required 00001111", bus.hi); end
        bus.hi_we = 1'b1; bus.hi_wdata = 32'h0000_1234;
        tick();
        bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("[TB] FAIL idle_write_hi: got %h required 00001234", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_2222) begin errors++; $display("[TB] FAIL idle_write_lo_kept: got %h required 00002222", bus.lo); end
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIVU, 32'd100, 32'd7);
        bus.op = OP_MULTU; bus.src_a = 32'd6; bus.src_b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: busy got %b required 1", bus.busy); end
        for (int i = 0; i < 33; i++) tick();
        checks++; if (bus.lo !== 32'd42) begin errors++; $display("[TB] FAIL b2b_lo: got %h required 0000002a", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL b2b_hi: got %h required 0", bus.hi); end
    endtask

`ifdef MULDIV_MADD_EN
    task automatic test_madd();
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hi_wdata = 32'd0; bus.lo_wdata = 32'd10;
        run_op(OP_MADD, 32'd3, 32'd4);
        checks++; if (bus.lo !== 32'd22) begin errors++; $display("[TB] FAIL madd_lo: got %h required 00000016", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL madd_hi: got %h required 0", bus.hi); end
        run_op(OP_MSUBU, 32'd5, 32'd5);
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL msubu_hi: got %h required ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL msubu_lo: got %h required fffffffd", bus.lo); end
        run_op(OP_MSUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL msub_hi: got %h required ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL msub_lo: got %h required fffffffc", bus.lo); end
    endtask
`else
    task automatic test_madd();
        direct_write(32'h0000_CAFE, 32'h0000_F00D);
        bus.op = OP_MADD; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL madd_off_busy: got %b required 0", bus.busy); end
        for (int i = 0; i < 40; i++) tick();
        checks++; if (bus.hi !== 32'h0000_CAFE) begin errors++; $display("[TB] FAIL madd_off_hi: got %h required 0000cafe", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_F00D) begin errors++; $display("[TB] FAIL madd_off_lo: got %h required 0000f00d", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL madd_off_busy_late: got %b required 0", bus.busy); end
    endtask
`endif

    task automatic test_reset_mid_div();
        direct_write(32'h0000_FFFF, 32'h0000_FFFF);
        bus.op = OP_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.hi !== '0) begin errors++; $display("[TB] FAIL rst_mid_hi: got %h required 0", bus.hi); end
        checks++; if (bus.lo !== '0) begin errors++; $display("[TB] FAIL rst_mid_lo: got %h required 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b required 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done: got %b required 0", bus.done); end
        run_op(OP_MULT, 32'd2, 32'd2);
        checks++; if (bus.lo !== 32'd4) begin errors++; $display("[TB] FAIL rst_then_mult_lo: got %h required 00000004", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL rst_then_mult_hi: got %h required 0", bus.hi); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'b000; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.hi_wdata = '0; bus.lo_wdata = '0;
        test_reset();
        test_mult_timing();
        test_vectors();
        test_flush();
        test_start_while_busy();
        test_direct_write();
        test_back_to_back();
        test_madd();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
